// File: rtl/move_capture.sv
// Confirm-button capture for the tic-tac-toe datapath: synchronise and debounce the
// button, then judge the selected cell against board occupancy with a one-cycle verdict.
module move_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] pos,
    input  logic [8:0] occupied,
    input  logic       enable,
    input  logic       btn_confirm,
    output logic       move_valid,
    output logic       move_reject,
    output logic [3:0] move_pos,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        ACCEPT   = 3'd2,
        REJECT   = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             sync1;
    logic             btn_s;
    logic             btn_db;
    logic             btn_db_q;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       pos_q;
    logic             press_evt_c;
    logic             capture_c;
    logic             legal_c;
    logic [15:0]      occ_ext_c;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= btn_confirm;
            btn_s <= sync1;
        end
    end

    // Debouncer: btn_db flips only after DEBOUNCE_CYCLES consecutive differing cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                btn_db <= ~btn_db;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press_evt_c = btn_db & ~btn_db_q;

    // Cells 9..15 are padded as taken; the range test short-circuits before that matters
    assign occ_ext_c = {7'h7f, occupied};
    assign legal_c   = (pos_q <= 4'd8) && !occ_ext_c[pos_q];

    always_comb begin
        state_n   = state;
        capture_c = 1'b0;
        case (state)
            IDLE: begin
                if (press_evt_c && enable) begin
                    state_n   = CHECK;
                    capture_c = 1'b1;
                end
            end
            CHECK:    state_n = legal_c ? ACCEPT : REJECT;
            ACCEPT:   state_n = WAIT_REL;
            REJECT:   state_n = WAIT_REL;
            WAIT_REL: state_n = btn_db ? WAIT_REL : IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // State and registered Moore outputs, decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pos_q       <= 4'd0;
            move_pos    <= 4'd0;
            move_valid  <= 1'b0;
            move_reject <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            move_valid  <= (state_n == ACCEPT);
            move_reject <= (state_n == REJECT);
            busy        <= (state_n != IDLE);
            if (capture_c) begin
                pos_q <= pos;
            end
            if (state == CHECK) begin
                move_pos <= pos_q;
            end
        end
    end

endmodule

// File: tb/tb_move_capture.sv
// Scoreboard bench for move_capture with a short debounce window.
module tb_move_capture;

    localparam int D = 4;

    typedef struct {
        logic       rej;
        logic [3:0] p;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pos;
    logic [8:0] occupied;
    logic       enable;
    logic       btn_confirm;
    logic       move_valid;
    logic       move_reject;
    logic [3:0] move_pos;
    logic       busy;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    move_capture #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .pos         (pos),
        .occupied    (occupied),
        .enable      (enable),
        .btn_confirm (btn_confirm),
        .move_valid  (move_valid),
        .move_reject (move_reject),
        .move_pos    (move_pos),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] p, input logic [8:0] occ);
        exp_t r;
        r.p = p;
        if (p > 4'd8) r.rej = 1'b1;
        else          r.rej = occ[p];
        return r;
    endfunction

    // Every verdict pulse is matched against the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && (move_valid || move_reject)) begin
            exp_t e;
            n_cmp++;
            if (move_valid && move_reject) begin
                n_bad++;
                $display("FAIL both_pulses: valid=%0b reject=%0b, required one-hot", move_valid, move_reject);
            end
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: valid=%0b reject=%0b pos=%0d, required no pulse",
                         move_valid, move_reject, move_pos);
            end else begin
                e = sb.pop_front();
                if ({move_reject, move_valid, move_pos} !== {e.rej, ~e.rej, e.p}) begin
                    n_bad++;
                    $display("FAIL verdict: got rej=%0b val=%0b pos=%0d, required rej=%0b val=%0b pos=%0d",
                             move_reject, move_valid, move_pos, e.rej, ~e.rej, e.p);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (sb.size() !== 0) begin
            n_bad++;
            $display("FAIL %s_drained: %0d verdicts outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic press_expect(input logic [3:0] p, input logic [8:0] occ, input string name);
        pos = p;
        occupied = occ;
        sb.push_back(model(p, occ));
        btn_confirm = 1'b1;
        tick(20);
        btn_confirm = 1'b0;
        tick(D + 8);
        check_drained(name);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        pos = 4'd0;
        occupied = 9'd0;
        enable = 1'b1;
        btn_confirm = 1'b0;
        tick(3);
        n_cmp++;
        if ({move_valid, move_reject, busy, move_pos} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: valid=%0b reject=%0b busy=%0b pos=%0d, required all 0",
                     move_valid, move_reject, busy, move_pos);
        end
        rst = 1'b0;
        tick(2);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_valid_latency;
        int k;
        pos = 4'd3;
        occupied = 9'd0;
        sb.push_back(model(4'd3, 9'd0));
        btn_confirm = 1'b1;
        k = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            k++;
            if (move_valid || move_reject) break;
        end
        n_cmp++;
        if (k !== 2 + D + 2) begin
            n_bad++;
            $display("FAIL latency: %0d cycles, required %0d", k, 2 + D + 2);
        end
        n_cmp++;
        if ({move_valid, move_reject, move_pos} !== {1'b1, 1'b0, 4'd3}) begin
            n_bad++;
            $display("FAIL first_verdict: valid=%0b reject=%0b pos=%0d, required 1 0 3",
                     move_valid, move_reject, move_pos);
        end
        tick(20 - k);
        btn_confirm = 1'b0;
        tick(D + 8);
        check_drained("valid");
    endtask

    task automatic test_occupied;
        press_expect(4'd3, 9'b000001000, "occupied");
        n_cmp++;
        if (move_pos !== 4'd3) begin
            n_bad++;
            $display("FAIL occupied_hold: move_pos=%0d, required 3", move_pos);
        end
    endtask

    task automatic test_out_of_range;
        press_expect(4'd12, 9'd0, "pos12");
        press_expect(4'd15, 9'h1ff, "pos15");
        press_expect(4'd0, 9'b111111110, "pos0");
        press_expect(4'd8, 9'b011111111, "pos8");
    endtask

    task automatic test_glitch;
        logic seen_busy;
        seen_busy = 1'b0;
        btn_confirm = 1'b1;
        tick(3);
        btn_confirm = 1'b0;
        for (int i = 0; i < D + 10; i++) begin
            tick(1);
            if (busy) seen_busy = 1'b1;
        end
        n_cmp++;
        if (seen_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_busy: busy seen=%0b, required 0", seen_busy);
        end
        check_drained("glitch");
    endtask

    task automatic test_enable;
        logic seen_busy;
        seen_busy = 1'b0;
        enable = 1'b0;
        pos = 4'd1;
        occupied = 9'd0;
        btn_confirm = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (busy) seen_busy = 1'b1;
        end
        btn_confirm = 1'b0;
        tick(D + 6);
        enable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (busy) seen_busy = 1'b1;
        end
        n_cmp++;
        if (seen_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL disabled_press: busy seen=%0b, required 0", seen_busy);
        end
        press_expect(4'd1, 9'd0, "reenabled");
    endtask

    task automatic test_pos_hold;
        int k;
        pos = 4'd2;
        occupied = 9'd0;
        sb.push_back(model(4'd2, 9'd0));
        btn_confirm = 1'b1;
        k = 0;
        while (!busy && k < 40) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL pos_hold_busy: busy=%0b after %0d cycles, required 1", busy, k);
        end
        pos = 4'd8;
        enable = 1'b0;
        tick(20);
        btn_confirm = 1'b0;
        tick(D + 8);
        enable = 1'b1;
        check_drained("pos_hold");
    endtask

    task automatic test_reset_mid;
        int k;
        pos = 4'd8;
        occupied = 9'd0;
        btn_confirm = 1'b1;
        k = 0;
        while (!busy && k < 40) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_busy: busy=%0b after %0d cycles, required 1", busy, k);
        end
        rst = 1'b1;
        btn_confirm = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(D + 8);
        n_cmp++;
        if ({busy, move_pos} !== {1'b0, 4'd0}) begin
            n_bad++;
            $display("FAIL reset_mid_state: busy=%0b pos=%0d, required 0 0", busy, move_pos);
        end
        check_drained("reset_mid");
        press_expect(4'd8, 9'd0, "repress");
        n_cmp++;
        if (move_pos !== 4'd8) begin
            n_bad++;
            $display("FAIL repress_pos: move_pos=%0d, required 8", move_pos);
        end
    endtask

    initial begin
        test_reset();
        test_valid_latency();
        test_occupied();
        test_out_of_range();
        test_glitch();
        test_enable();
        test_pos_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
